usb_rx_packet_buffer: RTL

- Sits directly downstream of the SIE receive stage and consumes its byte stream (data, valid, last-byte, keep-packet).
- Stores incoming bytes in a ring buffer and commits a packet only when its last byte arrives with keepPacket set and no overflow occurred. Otherwise it rolls the write pointer back, so the packet leaves no trace.
- Presents committed packets to the protocol backend through a valid/ready byte interface with per-byte last flags.

---
 rtl/sie_defs_pkg.sv | 25 ++
 rtl/usb_rx_buf_ram.sv | 25 ++
 rtl/usb_rx_packet_buffer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sie_defs_pkg.sv
// Shared types for the USB receive-side packet buffer: FSM states and the
// buffer memory word layout.
package sie_defs_pkg;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_RECV,
    WR_DISCARD
  } WrState_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_FETCH,
    RD_VALID
  } RdState_t;

  // One buffered byte plus the flag marking the end of its packet
  typedef struct packed {
    logic       is_last;
    logic [7:0] data;
  } mem_word_t;

  localparam int MEM_WORD_W = $bits(mem_word_t);

endpackage

// File: rtl/usb_rx_buf_ram.sv
// Simple dual-port buffer RAM: one write port, one registered read port.
// The array has no reset so it maps onto block RAM.
module usb_rx_buf_ram
  import sie_defs_pkg::*;
#(
  parameter int DEPTH_BITS = 7
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_BITS-1:0] wr_addr,
  input  logic [MEM_WORD_W-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [DEPTH_BITS-1:0] rd_addr,
  output logic [MEM_WORD_W-1:0] rd_data
);

  logic [MEM_WORD_W-1:0] mem [0:(1<<DEPTH_BITS)-1];

  // Write port and synchronous read port share the one clock
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/usb_rx_packet_buffer.sv
// Receive packet buffer behind the SIE: stores bytes in a ring, commits a
// packet only when it ends cleanly, and replays committed packets to the
// protocol backend over a valid/ready byte interface.
module usb_rx_packet_buffer
  import sie_defs_pkg::*;
#(
  parameter int DEPTH_BITS = 7
) (
  input  logic                  clk12_i,
  input  logic                  rst_n_i,
  input  logic                  rxDataValid_i,
  input  logic [7:0]            rxData_i,
  input  logic                  rxIsLastByte_i,
  input  logic                  keepPacket_i,
  output logic                  rxAcceptNewData_o,
  input  logic                  flush_i,
  output logic                  rdValid_o,
  output logic [7:0]            rdData_o,
  output logic                  rdIsLast_o,
  input  logic                  rdReady_i,
  output logic [DEPTH_BITS:0]   packetCount_o,
  output logic                  packetDropped_o
);

  localparam int PW = DEPTH_BITS + 1;
  localparam logic [PW-1:0] DEPTH = PW'(1) << DEPTH_BITS;

  WrState_t        wr_state_q, wr_state_d;
  RdState_t        rd_state_q, rd_state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   count_q, count_d;
  logic            drop_q, drop_d;
  logic            accept_q;
  logic            rd_valid_q, rd_valid_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            rd_last_q, rd_last_d;

  logic            rx_hs, rd_hs, full, committed_non_empty, commit;
  logic            ram_wr_en, ram_rd_en;
  mem_word_t       ram_wr_word, ram_rd_word;

  assign rx_hs               = rxDataValid_i && accept_q;
  assign rd_hs               = rd_valid_q && rdReady_i;
  assign full                = (wr_ptr_q - rd_ptr_q) == DEPTH;
  assign committed_non_empty = rd_ptr_q != commit_ptr_q;

  usb_rx_buf_ram #(.DEPTH_BITS(DEPTH_BITS)) u_ram (
    .clk     (clk12_i),
    .wr_en   (ram_wr_en),
    .wr_addr (wr_ptr_q[DEPTH_BITS-1:0]),
    .wr_data (ram_wr_word),
    .rd_en   (ram_rd_en),
    .rd_addr (rd_ptr_q[DEPTH_BITS-1:0]),
    .rd_data (ram_rd_word)
  );

  // Write side: store bytes, then commit or roll back at the packet's last byte
  always_comb begin
    wr_state_d   = wr_state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    drop_d       = 1'b0;
    commit       = 1'b0;
    ram_wr_en    = 1'b0;
    ram_wr_word  = '{is_last: rxIsLastByte_i, data: rxData_i};
    if (flush_i) begin
      wr_ptr_d     = rd_ptr_q;
      commit_ptr_d = rd_ptr_q;
      if (rx_hs) begin
        wr_state_d = rxIsLastByte_i ? WR_IDLE : WR_DISCARD;
      end else if (wr_state_q == WR_RECV) begin
        wr_state_d = WR_DISCARD;
      end
    end else if (rx_hs) begin
      if (rxIsLastByte_i) begin
        wr_state_d = WR_IDLE;
        if (keepPacket_i && (wr_state_q != WR_DISCARD) && !full) begin
          ram_wr_en    = 1'b1;
          wr_ptr_d     = wr_ptr_q + PW'(1);
          commit_ptr_d = wr_ptr_q + PW'(1);
          commit       = 1'b1;
        end else begin
          wr_ptr_d = commit_ptr_q;
          drop_d   = 1'b1;
        end
      end else if (wr_state_q != WR_DISCARD) begin
        if (full) begin
          wr_state_d = WR_DISCARD;
        end else begin
          ram_wr_en  = 1'b1;
          wr_ptr_d   = wr_ptr_q + PW'(1);
          wr_state_d = WR_RECV;
        end
      end
    end
  end

  // Read side: fetch one committed byte at a time into the output register
  always_comb begin
    rd_state_d = rd_state_q;
    rd_ptr_d   = rd_ptr_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    rd_last_d  = rd_last_q;
    ram_rd_en  = 1'b0;
    if (flush_i) begin
      rd_state_d = RD_IDLE;
      rd_valid_d = 1'b0;
    end else begin
      case (rd_state_q)
        RD_IDLE: begin
          if (committed_non_empty) begin
            ram_rd_en  = 1'b1;
            rd_state_d = RD_FETCH;
          end
        end
        RD_FETCH: begin
          rd_data_d  = ram_rd_word.data;
          rd_last_d  = ram_rd_word.is_last;
          rd_valid_d = 1'b1;
          rd_ptr_d   = rd_ptr_q + PW'(1);
          rd_state_d = RD_VALID;
        end
        RD_VALID: begin
          if (rd_hs) begin
            rd_valid_d = 1'b0;
            if (committed_non_empty) begin
              ram_rd_en  = 1'b1;
              rd_state_d = RD_FETCH;
            end else begin
              rd_state_d = RD_IDLE;
            end
          end
        end
        default: rd_state_d = RD_IDLE;
      endcase
    end
  end

  // Committed-packet count: up on commit, down when a packet's last byte leaves
  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      case ({commit, rd_hs && rd_last_q})
        2'b10:   count_d = count_q + PW'(1);
        2'b01:   count_d = count_q - PW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State, pointer and output registers
  always_ff @(posedge clk12_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_state_q   <= WR_IDLE;
      rd_state_q   <= RD_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      drop_q       <= 1'b0;
      accept_q     <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      rd_last_q    <= 1'b0;
    end else begin
      wr_state_q   <= wr_state_d;
      rd_state_q   <= rd_state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      drop_q       <= drop_d;
      accept_q     <= 1'b1;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      rd_last_q    <= rd_last_d;
    end
  end

  assign rxAcceptNewData_o = accept_q;
  assign rdValid_o         = rd_valid_q;
  assign rdData_o          = rd_data_q;
  assign rdIsLast_o        = rd_last_q;
  assign packetCount_o     = count_q;
  assign packetDropped_o   = drop_q;

endmodule
